lsu_mem_req_serializer: RTL and testbench

- Sits directly downstream of the LSU address calculator. Captures one wavefront's 64 per-lane load/store addresses, plus the exec mask and store data.
- Issues one 32-bit memory request per active lane, lowest lane first, over a valid/ready handshake to the global memory or LDS port.
- Pulses a completion strobe when every active lane has been issued.

---
 rtl/lsu_mem_req_serializer.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mem_req_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_req_serializer.sv
// lsu_mem_req_serializer
// Captures one wavefront of per-lane load/store addresses, store data and the
// exec mask, then issues one memory request per active lane, lowest lane
// first, over a valid/ready handshake. A one-cycle done strobe follows the
// last issued lane.
module lsu_mem_req_serializer #(
    parameter int NUM_LANES  = 64,
    parameter int LANE_IDX_W = 6,
    parameter int ADDR_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        out_in_ready,
    input  logic [NUM_LANES*ADDR_W-1:0] in_ld_st_addr,
    input  logic [NUM_LANES*32-1:0]     in_store_data,
    input  logic [NUM_LANES-1:0]        in_exec_mask,
    input  logic                        in_wr_en,
    input  logic                        in_gm_or_lds,
    output logic                        out_mem_valid,
    input  logic                        in_mem_ready,
    output logic [ADDR_W-1:0]           out_mem_addr,
    output logic [31:0]                 out_mem_data,
    output logic                        out_mem_wr_en,
    output logic                        out_mem_gm_or_lds,
    output logic [LANE_IDX_W-1:0]       out_mem_lane,
    output logic                        out_done,
    output logic                        out_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // FSM and pending-lane bookkeeping
    state_t                 state_r;
    state_t                 state_s;
    logic [NUM_LANES-1:0]   pending_r;
    logic [NUM_LANES-1:0]   pending_s;
    logic                   accept_s;

    // Latched wavefront payload
    logic [ADDR_W-1:0]      addr_mem_r [NUM_LANES];
    logic [31:0]            data_mem_r [NUM_LANES];
    logic                   wr_en_r;
    logic                   gm_or_lds_r;

    // Current-lane selection
    logic [LANE_IDX_W-1:0]  lane_s;
    logic [NUM_LANES-1:0]   lane_onehot_s;
    logic                   issuing_s;

    // Priority encoder: index of the lowest set bit (0 for an empty mask).
    // Scanning from the top down lets the lowest set bit overwrite last.
    function automatic logic [LANE_IDX_W-1:0] lowest_set(
        input logic [NUM_LANES-1:0] mask
    );
        logic [LANE_IDX_W-1:0] idx;
        idx = {LANE_IDX_W{1'b0}};
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = LANE_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Lane selection derived from the registered pending mask only.
    always_comb begin
        lane_s        = lowest_set(pending_r);
        lane_onehot_s = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_s;
        issuing_s     = (state_r == ST_ISSUE) && (pending_r != {NUM_LANES{1'b0}});
    end

    // Next-state and pending-mask update.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s  = 1'b1;
                    pending_s = in_exec_mask;
                    if (in_exec_mask != {NUM_LANES{1'b0}}) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!issuing_s) begin
                    // Nothing left to issue; close out the wavefront.
                    state_s   = ST_DONE;
                    pending_s = {NUM_LANES{1'b0}};
                end else if (in_mem_ready) begin
                    pending_s = pending_r & ~lane_onehot_s;
                    if ((pending_r & ~lane_onehot_s) == {NUM_LANES{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_s   = ST_IDLE;
                pending_s = {NUM_LANES{1'b0}};
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = {NUM_LANES{1'b0}};
            end
        endcase
    end

    // State and pending-mask registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pending_r <= {NUM_LANES{1'b0}};
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
        end
    end

    // Request attributes captured at wavefront accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_r     <= 1'b0;
            gm_or_lds_r <= 1'b0;
        end else if (accept_s) begin
            wr_en_r     <= in_wr_en;
            gm_or_lds_r <= in_gm_or_lds;
        end else begin
            wr_en_r     <= wr_en_r;
            gm_or_lds_r <= gm_or_lds_r;
        end
    end

    // Per-lane address and store-data capture at wavefront accept. The
    // payload is only observed while issuing, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_mem_r[i] <= in_ld_st_addr[i*ADDR_W +: ADDR_W];
                data_mem_r[i] <= in_store_data[i*32 +: 32];
            end
        end
    end

    // Output decode from registered state; request fields are zero unless a
    // request is being presented, and store data is zero for loads.
    always_comb begin
        out_in_ready      = (state_r == ST_IDLE);
        out_done          = (state_r == ST_DONE);
        out_busy          = (state_r == ST_ISSUE) || (state_r == ST_DONE);
        out_mem_valid     = issuing_s;
        out_mem_addr      = {ADDR_W{1'b0}};
        out_mem_data      = 32'h0;
        out_mem_wr_en     = 1'b0;
        out_mem_gm_or_lds = 1'b0;
        out_mem_lane      = {LANE_IDX_W{1'b0}};
        if (issuing_s) begin
            out_mem_addr      = addr_mem_r[lane_s];
            out_mem_data      = wr_en_r ? data_mem_r[lane_s] : 32'h0;
            out_mem_wr_en     = wr_en_r;
            out_mem_gm_or_lds = gm_or_lds_r;
            out_mem_lane      = lane_s;
        end else begin
            out_mem_addr = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_lsu_mem_req_serializer.sv
// Self-checking bench for lsu_mem_req_serializer: directed and random
// wavefronts compared against a queue-based model of the expected request
// stream (ascending active lanes) and the done timing.
module tb_lsu_mem_req_serializer;

    localparam int NL = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            out_in_ready;
    logic [NL*32-1:0] in_ld_st_addr;
    logic [NL*32-1:0] in_store_data;
    logic [NL-1:0]   in_exec_mask;
    logic            in_wr_en;
    logic            in_gm_or_lds;
    logic            out_mem_valid;
    logic            in_mem_ready;
    logic [31:0]     out_mem_addr;
    logic [31:0]     out_mem_data;
    logic            out_mem_wr_en;
    logic            out_mem_gm_or_lds;
    logic [5:0]      out_mem_lane;
    logic            out_done;
    logic            out_busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] lane_addr [NL];
    logic [31:0] lane_data [NL];

    typedef struct {
        logic [5:0]  lane;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        gm;
    } req_t;
    req_t q[$];

    always #5 clk = ~clk;

    lsu_mem_req_serializer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .out_in_ready      (out_in_ready),
        .in_ld_st_addr     (in_ld_st_addr),
        .in_store_data     (in_store_data),
        .in_exec_mask      (in_exec_mask),
        .in_wr_en          (in_wr_en),
        .in_gm_or_lds      (in_gm_or_lds),
        .out_mem_valid     (out_mem_valid),
        .in_mem_ready      (in_mem_ready),
        .out_mem_addr      (out_mem_addr),
        .out_mem_data      (out_mem_data),
        .out_mem_wr_en     (out_mem_wr_en),
        .out_mem_gm_or_lds (out_mem_gm_or_lds),
        .out_mem_lane      (out_mem_lane),
        .out_done          (out_done),
        .out_busy          (out_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NL; i++) begin
            in_ld_st_addr[i*32 +: 32] = $urandom;
            in_store_data[i*32 +: 32] = $urandom;
        end
        in_exec_mask = {$urandom, $urandom};
        in_wr_en     = 1'($urandom_range(0, 1));
        in_gm_or_lds = 1'($urandom_range(0, 1));
    endtask

    task automatic randomize_lanes();
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = $urandom;
            lane_data[i] = $urandom;
        end
    endtask

    // Called at a negedge with the DUT idle. mode: 0 = ready always high,
    // 1 = ready low for 3 cycles at each request, 2 = random ready.
    // abort_after >= 0 applies reset once that many handshakes are done.
    task automatic run_wave(input logic [63:0] exec, input logic wr, input logic gm,
                            input int mode, input int abort_after);
        int   n;
        int   hs;
        int   stall;
        logic rdy;
        logic done_due;
        chk("in_ready_before_accept", 64'(out_in_ready), 64'd1);
        for (int i = 0; i < NL; i++) begin
            in_ld_st_addr[i*32 +: 32] = lane_addr[i];
            in_store_data[i*32 +: 32] = lane_data[i];
        end
        in_exec_mask = exec;
        in_wr_en     = wr;
        in_gm_or_lds = gm;
        in_valid     = 1'b1;
        q.delete();
        for (int i = 0; i < NL; i++) begin
            if (exec[i]) q.push_back('{6'(i), lane_addr[i], (wr ? lane_data[i] : 32'h0), wr, gm});
        end
        n        = q.size();
        done_due = (n == 0);
        hs       = 0;
        stall    = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (abort_after >= 0 && hs == abort_after) begin
                rst_n        = 1'b0;
                in_mem_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                chk("rst_mid_valid", 64'(out_mem_valid), 64'd0);
                chk("rst_mid_done", 64'(out_done), 64'd0);
                chk("rst_mid_in_ready", 64'(out_in_ready), 64'd1);
                chk("rst_mid_busy", 64'(out_busy), 64'd0);
                chk("rst_mid_addr", 64'(out_mem_addr), 64'd0);
                chk("rst_mid_lane", 64'(out_mem_lane), 64'd0);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_valid", 64'(out_mem_valid), 64'd0);
                    chk("post_rst_done", 64'(out_done), 64'd0);
                end
                in_mem_ready = 1'b0;
                return;
            end
            if (done_due) begin
                chk("done_pulse", 64'(out_done), 64'd1);
                chk("done_valid", 64'(out_mem_valid), 64'd0);
                chk("done_busy", 64'(out_busy), 64'd1);
                chk("done_in_ready", 64'(out_in_ready), 64'd0);
                chk("handshake_count", 64'(hs), 64'(n));
                if (mode == 0) chk("done_latency", 64'(cyc), 64'(n + 1));
                in_mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("done_single", 64'(out_done), 64'd0);
                chk("idle_in_ready", 64'(out_in_ready), 64'd1);
                chk("idle_busy", 64'(out_busy), 64'd0);
                chk("idle_valid", 64'(out_mem_valid), 64'd0);
                in_mem_ready = 1'b0;
                return;
            end
            chk("issue_done", 64'(out_done), 64'd0);
            chk("issue_valid", 64'(out_mem_valid), 64'd1);
            chk("issue_busy", 64'(out_busy), 64'd1);
            chk("issue_in_ready", 64'(out_in_ready), 64'd0);
            chk("req_lane", 64'(out_mem_lane), 64'(q[0].lane));
            chk("req_addr", 64'(out_mem_addr), 64'(q[0].addr));
            chk("req_data", 64'(out_mem_data), 64'(q[0].data));
            chk("req_wr_en", 64'(out_mem_wr_en), 64'(q[0].wr));
            chk("req_gm_or_lds", 64'(out_mem_gm_or_lds), 64'(q[0].gm));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (stall == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            in_mem_ready = rdy;
            if (rdy) begin
                void'(q.pop_front());
                hs++;
                stall = 0;
                if (q.size() == 0) done_due = 1'b1;
            end else begin
                stall++;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $error("FAIL wave_timeout observed=no_done expected=done_within_2000_cycles");
        in_mem_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        in_mem_ready = 1'b0;
        scramble_inputs();

        // Reset held with in_valid high.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(out_in_ready), 64'd1);
        chk("rst_valid", 64'(out_mem_valid), 64'd0);
        chk("rst_done", 64'(out_done), 64'd0);
        chk("rst_busy", 64'(out_busy), 64'd0);
        chk("rst_lane", 64'(out_mem_lane), 64'd0);
        chk("rst_wr_en", 64'(out_mem_wr_en), 64'd0);

        // Full mask, continuous ready, accepted on the first edge after release.
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 32'h1000 + 32'(4 * i);
            lane_data[i] = $urandom;
        end
        rst_n = 1'b1;
        run_wave(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, -1);

        // Sparse mask with 3-cycle stalls at each request.
        randomize_lanes();
        run_wave(64'h8000_0000_0000_0005, 1'b0, 1'b1, 1, -1);

        // Empty mask.
        randomize_lanes();
        run_wave(64'h0, 1'b1, 1'b0, 0, -1);

        // Store path, then the same lane as a load.
        randomize_lanes();
        lane_data[5] = 32'hDEAD_BEEF;
        run_wave(64'h1 << 5, 1'b1, 1'b1, 0, -1);
        run_wave(64'h1 << 5, 1'b0, 1'b0, 0, -1);

        // Lane 63 only.
        randomize_lanes();
        run_wave(64'h8000_0000_0000_0000, 1'b1, 1'b0, 2, -1);

        // Reset after 10 of 64 handshakes, then a fresh wavefront.
        for (int i = 0; i < NL; i++) lane_addr[i] = 32'h1000 + 32'(4 * i);
        run_wave(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 10);
        randomize_lanes();
        run_wave({$urandom, $urandom} | 64'h0000_0100_0000_0000, 1'b1, 1'b1, 2, -1);

        // Random wavefronts with random backpressure.
        for (int w = 0; w < 10; w++) begin
            logic [63:0] m;
            randomize_lanes();
            m = {$urandom, $urandom};
            if (w % 3 == 1) m = m & {$urandom, $urandom} & {$urandom, $urandom};
            run_wave(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (w % 2 == 0) ? 2 : 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
